// File: rtl/sdram_line_fill.sv
// Cache line-fill engine: one SDRAM burst per request, halfword beats packed
// big-endian into 32-bit words and written critical-word-first into the line RAM.
module sdram_line_fill #(
  parameter int unsigned depth     = 8,
  parameter int unsigned line_log2 = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       fill_req,
  input  logic [depth-line_log2-1:0] fill_line,
  input  logic [line_log2:0]         fill_crit,
  output logic                       fill_ack,
  output logic                       fill_done,
  output logic                       busy,
  output logic                       sdram_req,
  input  logic                       sdram_ack,
  input  logic                       sdram_valid,
  input  logic [15:0]                sdram_data,
  output logic                       ram_wren,
  output logic [depth-1:0]           ram_addr,
  output logic [31:0]                ram_data
);

  localparam int unsigned LINE_W = depth - line_log2;
  localparam int unsigned CNT_W  = line_log2 + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [CNT_W-1:0]  crit_q, crit_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [15:0]       hold_q, hold_d;
  logic [15:0]       first_lo_q, first_lo_d;
  logic              fill_ack_q, fill_ack_d;
  logic              fill_done_q, fill_done_d;
  logic              busy_q, busy_d;
  logic              sdram_req_q, sdram_req_d;
  logic              ram_wren_q, ram_wren_d;
  logic [depth-1:0]  ram_addr_q, ram_addr_d;
  logic [31:0]       ram_data_q, ram_data_d;

  logic [CNT_W-1:0]  half_idx;
  logic              last_beat;
  logic              first_beat;

  // Halfword position wraps inside the line through natural counter overflow.
  assign half_idx   = crit_q + beat_q;
  assign last_beat  = &beat_q;
  assign first_beat = (beat_q == '0);

  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    crit_d      = crit_q;
    beat_d      = beat_q;
    hold_d      = hold_q;
    first_lo_d  = first_lo_q;
    fill_ack_d  = 1'b0;
    fill_done_d = 1'b0;
    busy_d      = busy_q;
    sdram_req_d = sdram_req_q;
    ram_wren_d  = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_data_d  = ram_data_q;

    case (state_q)
      S_IDLE: begin
        if (fill_req) begin
          line_d      = fill_line;
          crit_d      = fill_crit;
          fill_ack_d  = 1'b1;
          busy_d      = 1'b1;
          sdram_req_d = 1'b1;
          state_d     = S_REQ;
        end
      end

      S_REQ: begin
        if (sdram_ack) begin
          sdram_req_d = 1'b0;
          beat_d      = '0;
          state_d     = S_FILL;
        end
      end

      S_FILL: begin
        if (sdram_valid) begin
          beat_d = beat_q + CNT_W'(1);
          if (half_idx[0]) begin
            // An odd critical beat has no partner yet; park it until the line wraps.
            if (first_beat) begin
              first_lo_d = sdram_data;
            end else begin
              ram_wren_d = 1'b1;
              ram_addr_d = {line_q, half_idx[CNT_W-1:1]};
              ram_data_d = {hold_q, sdram_data};
            end
          end else if (last_beat && crit_q[0]) begin
            ram_wren_d = 1'b1;
            ram_addr_d = {line_q, half_idx[CNT_W-1:1]};
            ram_data_d = {sdram_data, first_lo_q};
          end else begin
            hold_d = sdram_data;
          end
          if (last_beat) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        // First cycle lets the final write land, second presents fill_done.
        if (fill_done_q) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          fill_done_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      line_q      <= '0;
      crit_q      <= '0;
      beat_q      <= '0;
      hold_q      <= '0;
      first_lo_q  <= '0;
      fill_ack_q  <= 1'b0;
      fill_done_q <= 1'b0;
      busy_q      <= 1'b0;
      sdram_req_q <= 1'b0;
      ram_wren_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      crit_q      <= crit_d;
      beat_q      <= beat_d;
      hold_q      <= hold_d;
      first_lo_q  <= first_lo_d;
      fill_ack_q  <= fill_ack_d;
      fill_done_q <= fill_done_d;
      busy_q      <= busy_d;
      sdram_req_q <= sdram_req_d;
      ram_wren_q  <= ram_wren_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
    end
  end

  assign fill_ack  = fill_ack_q;
  assign fill_done = fill_done_q;
  assign busy      = busy_q;
  assign sdram_req = sdram_req_q;
  assign ram_wren  = ram_wren_q;
  assign ram_addr  = ram_addr_q;
  assign ram_data  = ram_data_q;

endmodule

// File: tb/tb_sdram_line_fill.sv
// Bench for sdram_line_fill: directed fills, expected writes/acks/dones queued
// with their due cycle and matched by an output monitor.
module tb_sdram_line_fill;

  logic        clock = 1'b0;
  logic        reset;
  logic        fill_req;
  logic [5:0]  fill_line;
  logic [2:0]  fill_crit;
  logic        fill_ack, fill_done, busy, sdram_req;
  logic        sdram_ack, sdram_valid;
  logic [15:0] sdram_data;
  logic        ram_wren;
  logic [7:0]  ram_addr;
  logic [31:0] ram_data;

  sdram_line_fill #(.depth(8), .line_log2(2)) dut (
    .clock(clock), .reset(reset),
    .fill_req(fill_req), .fill_line(fill_line), .fill_crit(fill_crit),
    .fill_ack(fill_ack), .fill_done(fill_done), .busy(busy),
    .sdram_req(sdram_req), .sdram_ack(sdram_ack),
    .sdram_valid(sdram_valid), .sdram_data(sdram_data),
    .ram_wren(ram_wren), .ram_addr(ram_addr), .ram_data(ram_data)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t wr_q[$];
  int  done_q[$];
  int  ack_q[$];

  int checks = 0;
  int errors = 0;

  logic [31:0] model_ram [256];
  bit          model_vld [256];
  logic [31:0] dut_ram   [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: every observed pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    if (!reset) begin
      if (ram_wren) begin
        dut_ram[ram_addr] = ram_data;
        if (wr_q.size() == 0) begin
          check("unexpected_ram_wren", 32'(ram_addr), 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          check("wr_addr", 32'(ram_addr), 32'(e.addr));
          check("wr_data", ram_data, e.data);
          check("wr_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (fill_done) begin
        if (done_q.size() == 0) check("unexpected_fill_done", 32'(cyc), 32'hFFFF_FFFF);
        else check("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
      end
      if (fill_ack) begin
        if (ack_q.size() == 0) check("unexpected_fill_ack", 32'(cyc), 32'hFFFF_FFFF);
        else check("ack_cycle", 32'(cyc), 32'(ack_q.pop_front()));
      end
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_fill_ack"},  32'(fill_ack),  32'd0);
    check({tag, "_fill_done"}, 32'(fill_done), 32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_sdram_req"}, 32'(sdram_req), 32'd0);
    check({tag, "_ram_wren"},  32'(ram_wren),  32'd0);
    check({tag, "_ram_addr"},  32'(ram_addr),  32'd0);
    check({tag, "_ram_data"},  ram_data,       32'd0);
  endtask

  // Runs one fill starting in an IDLE cycle; returns in the cycle busy falls
  // (or just after asserting reset when abort_after >= 0).
  task automatic run_fill(input logic [5:0] line, input logic [2:0] crit,
                          input logic [15:0] beats [8], input int gap,
                          input bit stray, input bit hold_req, input int ack_delay,
                          input int abort_after, input bit poke_req);
    logic [15:0] half [8];
    bit          got  [8];
    int          cb;
    int          h;
    int          w;
    int          n;
    logic [7:0]  a;
    for (int i = 0; i < 8; i++) got[i] = 1'b0;

    fill_line = line;
    fill_crit = crit;
    fill_req  = 1'b1;
    ack_q.push_back(cyc + 1);
    next_cycle();
    fill_req = hold_req;

    for (int k = 0; k < ack_delay; k++) begin
      sdram_valid = stray;
      sdram_data  = 16'hDEAD;
      check("req_held", 32'(sdram_req), 32'd1);
      check("busy_in_req", 32'(busy), 32'd1);
      next_cycle();
    end
    sdram_ack   = 1'b1;
    sdram_valid = stray;
    sdram_data  = 16'hDEAD;
    next_cycle();
    sdram_ack   = 1'b0;
    sdram_valid = 1'b0;
    check("req_dropped", 32'(sdram_req), 32'd0);

    for (int b = 0; b < 8; b++) begin
      for (int g = 0; g < gap; g++) begin
        sdram_valid = 1'b0;
        next_cycle();
      end
      sdram_valid = 1'b1;
      sdram_data  = beats[b];
      if (poke_req && b == 2) fill_req = 1'b1;
      cb = cyc;
      h = (int'(crit) + b) % 8;
      half[h] = beats[b];
      got[h]  = 1'b1;
      w = h / 2;
      if (got[2*w] && got[2*w+1]) begin
        wr_t e;
        a = {line, w[1:0]};
        e.addr = a;
        e.data = {half[2*w], half[2*w+1]};
        e.cyc  = cb + 1;
        wr_q.push_back(e);
        model_ram[a] = e.data;
        model_vld[a] = 1'b1;
      end
      if (b == 7) done_q.push_back(cb + 2);
      next_cycle();
      fill_req = hold_req;
      if (b == abort_after) begin
        sdram_valid = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b1;
        #1;
        check_idle_outputs("abort");
        return;
      end
    end

    sdram_valid = stray;
    sdram_data  = 16'hBEEF;
    next_cycle();
    sdram_valid = 1'b0;
    check("busy_in_done", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 10) begin
      next_cycle();
      n++;
    end
    check("busy_fall", 32'(busy), 32'd0);
    check("busy_fall_cycle", 32'(cyc), 32'(cb + 3));
  endtask

  logic [15:0] bv_a [8];
  logic [15:0] bv_b [8];
  logic [15:0] bv_c [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      model_vld[i] = 1'b0;
      model_ram[i] = 32'd0;
      dut_ram[i]   = 32'd0;
    end
    for (int i = 0; i < 8; i++) begin
      bv_a[i] = 16'(16'h1111 * (i + 1));
      bv_b[i] = 16'(16'hA000 + i);
      bv_c[i] = 16'(16'hC000 + 16'h0101 * i);
    end
    reset       = 1'b1;
    fill_req    = 1'b0;
    fill_line   = '0;
    fill_crit   = '0;
    sdram_ack   = 1'b0;
    sdram_valid = 1'b0;
    sdram_data  = '0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    next_cycle();
    check_idle_outputs("reset");

    // Request stalled 20 cycles without ack, then completes.
    run_fill(6'h01, 3'd0, bv_c, 0, 1'b0, 1'b0, 20, -1, 1'b0);
    // Aligned critical word, back-to-back beats.
    run_fill(6'h05, 3'd0, bv_a, 0, 1'b0, 1'b0, 0, -1, 1'b0);
    // Odd critical halfword at the top line, wrap-around pairing.
    run_fill(6'h3F, 3'd5, bv_b, 0, 1'b0, 1'b0, 0, -1, 1'b0);
    // Gapped beats plus stray valid during REQ and after the last beat.
    run_fill(6'h12, 3'd2, bv_a, 3, 1'b1, 1'b0, 2, -1, 1'b0);

    // Reset mid-fill, then a clean fill with a request poked while busy.
    run_fill(6'h20, 3'd0, bv_c, 0, 1'b0, 1'b0, 0, 3, 1'b0);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    next_cycle();
    check_idle_outputs("post_abort");
    run_fill(6'h21, 3'd3, bv_b, 1, 1'b0, 1'b0, 1, -1, 1'b1);

    // Back-to-back fills with fill_req held high across the boundary.
    run_fill(6'h30, 3'd1, bv_a, 0, 1'b0, 1'b1, 0, -1, 1'b0);
    run_fill(6'h31, 3'd6, bv_c, 0, 1'b0, 1'b0, 0, -1, 1'b0);
    fill_req = 1'b0;
    next_cycle();
    next_cycle();

    for (int i = 0; i < 256; i++) begin
      if (model_vld[i]) check("ram_readback", dut_ram[i], model_ram[i]);
    end
    check("pending_writes", 32'(wr_q.size()), 32'd0);
    check("pending_dones",  32'(done_q.size()), 32'd0);
    check("pending_acks",   32'(ack_q.size()), 32'd0);
    check("final_busy",     32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
